// File: rtl/acq_sched_pkg.sv
// Shared types and constants for the acquisition sequencer: state encoding,
// error codes and helpers that map a state onto its handshake phase.
package acq_sched_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int TO_W_DEF  = 16;

  typedef enum logic [7:0] {
    S_IDLE  = 8'h00,
    S_CHECK = 8'h01,
    S_CONF  = 8'h02,
    S_PREP  = 8'h03,
    S_FITX  = 8'h04,
    S_FIRX  = 8'h05,
    S_CONT  = 8'h06,
    S_DTRX  = 8'h07,
    S_LAST  = 8'h08,
    S_ERR   = 8'h0F
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CHECK = 3'd1;
  localparam logic [2:0] ERR_CONF  = 3'd2;
  localparam logic [2:0] ERR_READ  = 3'd3;
  localparam logic [2:0] ERR_FIFO  = 3'd4;
  localparam logic [2:0] ERR_TX    = 3'd5;

  // Error code reported when the given state's handshake times out
  function automatic logic [2:0] phase_code(input state_t s);
    case (s)
      S_CHECK: return ERR_CHECK;
      S_CONF:  return ERR_CONF;
      S_FITX:  return ERR_READ;
      S_FIRX:  return ERR_FIFO;
      S_DTRX:  return ERR_TX;
      default: return ERR_NONE;
    endcase
  endfunction

  // States that wait on an external done level and so need a watchdog
  function automatic logic is_watched(input state_t s);
    return phase_code(s) != ERR_NONE;
  endfunction

endpackage

// File: rtl/acq_sched_if.sv
// Start/done handshake bundle between the sequencer and the sub-blocks it
// drives (ADC check/conf/read, FIFO fill, fifod2mac transmit).
interface acq_sched_if;
  logic fs_check, fs_conf, fs_read, fs_fifo, fs_tx;
  logic fd_check, fd_conf, fd_read, fd_fifo, fd_tx;

  modport master (
    output fs_check, fs_conf, fs_read, fs_fifo, fs_tx,
    input  fd_check, fd_conf, fd_read, fd_fifo, fd_tx
  );

  modport slave (
    input  fs_check, fs_conf, fs_read, fs_fifo, fs_tx,
    output fd_check, fd_conf, fd_read, fd_fifo, fd_tx
  );
endinterface

// File: rtl/acq_sched_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT-th cycle, after which the sequencer leaves the state.
module acq_sched_watchdog #(
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = '1
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] LIMIT = TIMEOUT - ONE;

  logic [TO_W-1:0] cnt;

  assign expired = en && (cnt == LIMIT);

  // Cycle counter, restarted whenever the sequencer changes state
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expired)  cnt <= cnt + ONE;
  end

endmodule

// File: rtl/acq_sched.sv
// Acquisition sequencer: ADC bring-up, then a loop of FIFO-space wait, ADC
// read, FIFO fill, and after adc_cnt frames a UDP packet hand-off, with a
// watchdog on every handshake phase and frame/packet counters for status.
module acq_sched
  import acq_sched_pkg::*;
#(
  parameter int              CNT_W   = CNT_W_DEF,
  parameter int              TO_W    = TO_W_DEF,
  parameter logic [TO_W-1:0] TIMEOUT = '1,
  parameter int              SYNC_N  = 2
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] adc_cnt,
  input  logic             fifo_full,
  acq_sched_if.master      hs,
  output logic [7:0]       state_o,
  output logic [CNT_W-1:0] frame_num,
  output logic [15:0]      pkt_cnt,
  output logic             err,
  output logic [2:0]       err_code
);

  localparam logic [CNT_W:0] ONE_W = {{CNT_W{1'b0}}, 1'b1};

  state_t state, state_n;
  logic [SYNC_N-1:0] fd_tx_sync;
  logic fd_tx_s;
  logic wd_clr, wd_en, wd_expired;
  logic [CNT_W:0] eff, frame_inc;
  logic more_frames;

  assign fd_tx_s     = fd_tx_sync[SYNC_N-1];
  assign eff         = (adc_cnt == '0) ? ONE_W : {1'b0, adc_cnt};
  assign frame_inc   = {1'b0, frame_num} + ONE_W;
  assign more_frames = frame_inc < eff;
  assign state_o     = state;
  assign wd_clr      = state_n != state;
  assign wd_en       = is_watched(state);

  acq_sched_watchdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_watchdog (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Bring the transmit-done level from the gmii_txc domain into sys_clk
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) fd_tx_sync <= '0;
    else     fd_tx_sync <= {fd_tx_sync[SYNC_N-2:0], hs.fd_tx};
  end

  // Next state; a done level arriving on the expiry cycle still advances
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (run) state_n = S_CHECK;
      S_CHECK: if (hs.fs_check && hs.fd_check) state_n = S_CONF;
               else if (wd_expired)             state_n = S_ERR;
      S_CONF:  if (hs.fs_conf && hs.fd_conf)   state_n = S_PREP;
               else if (wd_expired)             state_n = S_ERR;
      S_PREP:  if (!run)                        state_n = S_IDLE;
               else if (!fifo_full && !fd_tx_s) state_n = S_FITX;
      S_FITX:  if (hs.fs_read && hs.fd_read)   state_n = S_FIRX;
               else if (wd_expired)             state_n = S_ERR;
      S_FIRX:  if (hs.fs_fifo && hs.fd_fifo)   state_n = S_CONT;
               else if (wd_expired)             state_n = S_ERR;
      S_CONT:  state_n = more_frames ? S_LAST : S_DTRX;
      S_DTRX:  if (hs.fs_tx && fd_tx_s)        state_n = S_LAST;
               else if (wd_expired)             state_n = S_ERR;
      S_LAST:  state_n = S_PREP;
      S_ERR:   if (!run) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register with registered start strobes, counters and error status
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      hs.fs_check <= 1'b0;
      hs.fs_conf  <= 1'b0;
      hs.fs_read  <= 1'b0;
      hs.fs_fifo  <= 1'b0;
      hs.fs_tx    <= 1'b0;
      frame_num   <= '0;
      pkt_cnt     <= '0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state       <= state_n;
      hs.fs_check <= (state == S_CHECK) && (state_n == S_CHECK);
      hs.fs_conf  <= (state == S_CONF)  && (state_n == S_CONF);
      hs.fs_read  <= (state == S_FITX)  && (state_n == S_FITX);
      hs.fs_fifo  <= (state == S_FIRX)  && (state_n == S_FIRX);
      hs.fs_tx    <= (state == S_DTRX)  && (state_n == S_DTRX);
      if (state == S_PREP && state_n == S_IDLE)
        frame_num <= '0;
      if (state == S_CONT)
        frame_num <= more_frames ? frame_inc[CNT_W-1:0] : '0;
      if (state == S_DTRX && state_n == S_LAST)
        pkt_cnt <= pkt_cnt + 16'd1;
      if (state != S_ERR && state_n == S_ERR) begin
        err      <= 1'b1;
        err_code <= phase_code(state);
      end
      if (state == S_IDLE && state_n == S_CHECK) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

endmodule
